dpram_be_bist: RTL and testbench
================================

# dpram_be_bist

Built-in self-test initiator for the single-clock, true dual-port, byte-enable RAM used throughout the des90 designs. It drives both RAM ports as master: it fills the array through port A, checks it through port B, overwrites one byte lane per word through port B, then checks the merged words through port A. Mismatches are counted and the first failing address is reported. It sits between the RAM instance and the system control logic, and owns the RAM ports only while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, default 6: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, default 32: RAM word width. It must be a multiple of 8, and `BE_W = DATA_W/8` must be a power of 2.

Ports:
- `clk`, in, 1: the single clock. Every register updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: begins a test when sampled high in IDLE. Ignored at any other time.
- `pattern`, in, DATA_W: base data word. It is captured at start.
- `busy`, out, 1: test in progress.
- `done`, out, 1: one-cycle pulse at the end of a test.
- `pass`, out, 1: high when `fail_count == 0`. Valid from `done` until the next start.
- `fail_count`, out, 8: number of mismatching words. Saturates at 255.
- `fail_addr`, out, ADDR_W: address of the first mismatch.
- `fail_phase`, out, 1: 0 means the first mismatch was in CHECK1, 1 means CHECK2.
- `data_a`, `data_b`, out, DATA_W: RAM write data, ports A and B.
- `be_a`, `be_b`, out, BE_W: RAM byte enables.
- `addr_a`, `addr_b`, out, ADDR_W: RAM addresses.
- `we_a`, `we_b`, out, 1: RAM write enables.
- `q_a`, `q_b`, in, DATA_W: RAM registered read data. Read latency is 1 cycle.

## Operation
- States are IDLE, FILL, CHECK1, LANE, CHECK2 and DONE.
- An address counter `a` runs from 0 to 2^ADDR_W−1 in each of FILL, CHECK1, LANE and CHECK2.
- IDLE: `start` high captures `pattern` into P, clears all fail outputs, and moves to FILL.
- FILL:
  - Port A writes `data_a=P`, `be_a` all ones, `we_a=1`, `addr_a=a`.
  - At the last address, move to CHECK1.
- CHECK1:
  - Port B reads with `addr_b=a` and `we_b=0`.
  - The compare stage registers `{valid, addr}` and, one cycle later, checks `q_b` against P.
  - After the last address the state holds for 1 drain cycle, then moves to LANE.
- LANE:
  - Port B writes `data_b=~P`, `be_b = 1 << (a mod BE_W)`, `we_b=1`, `addr_b=a`.
  - At the last address, move to CHECK2.
- CHECK2:
  - Port A reads with `addr_a=a`, and the compare stage checks `q_a` one cycle later.
  - Expected word: P, with byte lane `(addr mod BE_W)` replaced by the same lane of ~P.
  - After 1 drain cycle, move to DONE.
- DONE: `done=1` for one cycle, then move to IDLE.
- On each mismatch:
  - `fail_count` increments, saturating at 255.
  - On the first mismatch only, `fail_addr` and `fail_phase` are captured.
- Write enables:
  - `we_a` is high only in FILL.
  - `we_b` is high only in LANE.
  - The two ports are never both written in the same cycle, so there are no address collisions.
- When a port is not in use, its address, data, byte-enable and write-enable outputs are driven to 0.

## Timing
- Reset:
  - State goes to IDLE.
  - `busy`, `done`, `pass`, `fail_count`, `fail_addr`, `fail_phase` and all RAM port outputs go to 0.
  - `pass` stays 0 until the first test completes.
- `rst` asserted mid-test aborts immediately. The RAM contents are then undefined, and no `done` is produced.
- For `start` sampled at edge E0:
  - `busy` is high from E0 for exactly 4·2^ADDR_W + 2 cycles (258 at default parameters).
  - `done` is high for the following cycle.
  - The block then spends at least 1 cycle in IDLE.
- If `start` is held high, a new test begins every 4·2^ADDR_W + 4 cycles (260 at default parameters).
- `pass`, `fail_*` and `done` all change on the same edge. `fail_*` is stable while `done` is high.
- The compare stage has a fixed 1-cycle skew: data returned in cycle t+1 is checked against the address issued in cycle t.
- The drain cycle drives no RAM access.

## Structure
- Package `dpram_bist_pkg` holds:
  - the state enum;
  - `BE_W` derivation;
  - function `lane_merge(P, lane)`, which returns the expected CHECK2 word.
- Sub-module `dpram_bist_checker` holds the compare pipeline:
  - registered valid/addr/phase;
  - comparator;
  - saturating `fail_count`;
  - first-fail capture.
- The top level holds the FSM, the address counter and the port muxing.

## Test plan
- Ideal behavioural RAM, `pattern=32'hA5C3_0F96`, one `start` pulse:
  - `busy` high for 258 cycles, then `done` for 1 cycle;
  - `pass=1`, `fail_count=0`.
- RAM model with bit 0 of address 5 stuck at 0, `pattern=32'hFFFF_FFFF`:
  - `fail_count=2` (one mismatch in CHECK1, one in CHECK2);
  - `fail_addr=5`, `fail_phase=0`, `pass=0`.
- RAM model that ignores `be` (writes full words):
  - CHECK1 passes;
  - CHECK2 fails every word, so `fail_count=64`, `fail_addr=0`, `fail_phase=1`.
- `rst` pulsed at cycle 100 of a test:
  - next cycle, all outputs are 0 and no `done` is produced;
  - a fresh `start` then gives a full 258-cycle test with `pass=1`.
- `start` held high with the ideal RAM:
  - `done` pulses exactly every 260 cycles;
  - `start` during `busy` has no effect on timing.
- Protocol check over the whole run:
  - `we_a` and `we_b` are never both high;
  - `be_b` is exactly one-hot in LANE and follows the sequence 1, 2, 4, 8, 1, ….

Source files
------------

// File: rtl/dpram_bist_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM self-test.
package dpram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CHECK1,
    ST_LANE,
    ST_CHECK2,
    ST_DONE
  } state_t;

  localparam int unsigned MAX_DATA_W = 1024;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Expected CHECK2 word: byte lane `lane` of p replaced by the same lane of ~p.
  function automatic logic [MAX_DATA_W-1:0] lane_merge(input logic [MAX_DATA_W-1:0] p,
                                                       input int unsigned lane);
    return p ^ (MAX_DATA_W'({8{1'b1}}) << (lane * 8));
  endfunction

endpackage

// File: rtl/dpram_be_bist_if.sv
// Both ports of the true dual-port byte-enable RAM, as seen by the self-test.
interface dpram_be_bist_if
  import dpram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = be_w(DATA_W);

  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [BE_W-1:0]   be_a;
  logic [BE_W-1:0]   be_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              we_a;
  logic              we_b;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;

  modport master (
    output data_a, data_b, be_a, be_b, addr_a, addr_b, we_a, we_b,
    input  q_a, q_b
  );

  modport slave (
    input  data_a, data_b, be_a, be_b, addr_a, addr_b, we_a, we_b,
    output q_a, q_b
  );
endinterface

// File: rtl/dpram_bist_checker.sv
// Compare pipeline: aligns issued read addresses with returned data and tracks failures.
module dpram_bist_checker
  import dpram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              finish,
  input  logic              rd_valid,
  input  logic              rd_phase,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] p,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_phase
);
  localparam int unsigned BE_W = be_w(DATA_W);

  logic              st_valid;
  logic              st_phase;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] exp_c;
  logic [DATA_W-1:0] got_c;
  logic              mismatch_c;
  logic [7:0]        cnt_c;

  // Phase 0 reads come back on port B, phase 1 reads on port A.
  always_comb begin
    exp_c      = p;
    got_c      = q_b;
    mismatch_c = 1'b0;
    cnt_c      = fail_count;
    if (st_phase) begin
      exp_c = DATA_W'(lane_merge(MAX_DATA_W'(p), 32'(st_addr) % BE_W));
      got_c = q_a;
    end
    mismatch_c = st_valid && (got_c != exp_c);
    if (clear) begin
      cnt_c = 8'd0;
    end else if (mismatch_c && fail_count != 8'hFF) begin
      cnt_c = fail_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid   <= 1'b0;
      st_phase   <= 1'b0;
      st_addr    <= '0;
      pass       <= 1'b0;
      fail_count <= 8'd0;
      fail_addr  <= '0;
      fail_phase <= 1'b0;
    end else begin
      st_valid   <= rd_valid;
      st_phase   <= rd_phase;
      st_addr    <= rd_addr;
      fail_count <= cnt_c;
      if (clear) begin
        fail_addr  <= '0;
        fail_phase <= 1'b0;
        pass       <= 1'b0;
      end else begin
        if (mismatch_c && fail_count == 8'd0) begin
          fail_addr  <= st_addr;
          fail_phase <= st_phase;
        end
        if (finish) begin
          pass <= (cnt_c == 8'd0);
        end
      end
    end
  end
endmodule

// File: rtl/dpram_be_bist.sv
// Self-test initiator: fill via A, check via B, lane-overwrite via B, check merged words via A.
module dpram_be_bist
  import dpram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_phase,
  dpram_be_bist_if.master   ram
);
  localparam int unsigned BE_W = be_w(DATA_W);
  localparam logic [ADDR_W-1:0] A_LAST = '1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] a, a_n;
  logic              drain, drain_n;
  logic [DATA_W-1:0] p, p_n;
  logic              clear_c, finish_c;

  logic [DATA_W-1:0] data_a_n, data_b_n;
  logic [BE_W-1:0]   be_a_n, be_b_n;
  logic [ADDR_W-1:0] addr_a_n, addr_b_n;
  logic              we_a_n, we_b_n;
  logic              rd_valid, rd_valid_n;
  logic              rd_phase, rd_phase_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;

  always_comb begin
    state_n    = state;
    a_n        = a;
    drain_n    = drain;
    p_n        = p;
    clear_c    = 1'b0;
    finish_c   = 1'b0;
    data_a_n   = '0;
    data_b_n   = '0;
    be_a_n     = '0;
    be_b_n     = '0;
    addr_a_n   = '0;
    addr_b_n   = '0;
    we_a_n     = 1'b0;
    we_b_n     = 1'b0;
    rd_valid_n = 1'b0;
    rd_phase_n = 1'b0;
    rd_addr_n  = '0;

    case (state)
      ST_IDLE: if (start) begin
        state_n = ST_FILL;
        a_n     = '0;
        drain_n = 1'b0;
        p_n     = pattern;
        clear_c = 1'b1;
      end
      ST_FILL, ST_LANE: begin
        a_n = a + ADDR_W'(1);
        if (a == A_LAST) state_n = (state == ST_FILL) ? ST_CHECK1 : ST_CHECK2;
      end
      // Each check phase holds one drain cycle so the last read gets compared.
      ST_CHECK1, ST_CHECK2: begin
        if (drain) begin
          drain_n = 1'b0;
          a_n     = '0;
          state_n = (state == ST_CHECK1) ? ST_LANE : ST_DONE;
        end else if (a == A_LAST) begin
          drain_n = 1'b1;
        end else begin
          a_n = a + ADDR_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    finish_c = (state_n == ST_DONE);

    // Port outputs are registered, so they decode the state being entered.
    case (state_n)
      ST_FILL: begin
        addr_a_n = a_n;
        data_a_n = p_n;
        be_a_n   = '1;
        we_a_n   = 1'b1;
      end
      ST_CHECK1: if (!drain_n) begin
        addr_b_n   = a_n;
        rd_valid_n = 1'b1;
        rd_addr_n  = a_n;
      end
      ST_LANE: begin
        addr_b_n = a_n;
        data_b_n = ~p_n;
        be_b_n   = BE_W'(1) << (32'(a_n) % BE_W);
        we_b_n   = 1'b1;
      end
      ST_CHECK2: if (!drain_n) begin
        addr_a_n   = a_n;
        rd_valid_n = 1'b1;
        rd_phase_n = 1'b1;
        rd_addr_n  = a_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      a          <= '0;
      drain      <= 1'b0;
      p          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram.data_a <= '0;
      ram.data_b <= '0;
      ram.be_a   <= '0;
      ram.be_b   <= '0;
      ram.addr_a <= '0;
      ram.addr_b <= '0;
      ram.we_a   <= 1'b0;
      ram.we_b   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_phase   <= 1'b0;
      rd_addr    <= '0;
    end else begin
      state      <= state_n;
      a          <= a_n;
      drain      <= drain_n;
      p          <= p_n;
      busy       <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done       <= finish_c;
      ram.data_a <= data_a_n;
      ram.data_b <= data_b_n;
      ram.be_a   <= be_a_n;
      ram.be_b   <= be_b_n;
      ram.addr_a <= addr_a_n;
      ram.addr_b <= addr_b_n;
      ram.we_a   <= we_a_n;
      ram.we_b   <= we_b_n;
      rd_valid   <= rd_valid_n;
      rd_phase   <= rd_phase_n;
      rd_addr    <= rd_addr_n;
    end
  end

  dpram_bist_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_c),
    .finish     (finish_c),
    .rd_valid   (rd_valid),
    .rd_phase   (rd_phase),
    .rd_addr    (rd_addr),
    .p          (p),
    .q_a        (ram.q_a),
    .q_b        (ram.q_b),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_addr  (fail_addr),
    .fail_phase (fail_phase)
  );
endmodule

// File: tb/tb_dpram_be_bist.sv
// Directed bench for dpram_be_bist with a behavioural RAM that can inject faults.
module tb_dpram_be_bist;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pattern;
  logic        busy, done, pass, fail_phase;
  logic [7:0]  fail_count;
  logic [5:0]  fail_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;        // 0 ideal, 1 addr 5 bit 0 stuck at 0, 2 byte enables ignored
  int proto_errs = 0;
  logic [31:0] mem [64];
  logic        snap_we_a;
  logic [5:0]  snap_addr_a;
  logic [31:0] snap_data_a;

  dpram_be_bist_if #(.ADDR_W(6), .DATA_W(32)) ram_if ();

  dpram_be_bist #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_addr  (fail_addr),
    .fail_phase (fail_phase),
    .ram        (ram_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input logic [5:0] addr);
    logic [31:0] w;
    w = mem[addr];
    if (mode == 1 && addr == 6'd5) w[0] = 1'b0;
    return w;
  endfunction

  // Behavioural RAM, registered read, one-cycle latency.
  always @(posedge clk) begin
    ram_if.q_a <= rd(ram_if.addr_a);
    ram_if.q_b <= rd(ram_if.addr_b);
    if (ram_if.we_a)
      mem[ram_if.addr_a] <= merge(mem[ram_if.addr_a], ram_if.data_a,
                                  (mode == 2) ? 4'hF : ram_if.be_a);
    if (ram_if.we_b)
      mem[ram_if.addr_b] <= merge(mem[ram_if.addr_b], ram_if.data_b,
                                  (mode == 2) ? 4'hF : ram_if.be_b);
  end

  // Port protocol monitor, summarised by test_protocol.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_if.we_a && ram_if.we_b) proto_errs <= proto_errs + 1;
      else if (ram_if.we_b && ram_if.be_b !== (4'b0001 << ram_if.addr_b[1:0]))
        proto_errs <= proto_errs + 1;
      else if (ram_if.we_a && ram_if.be_a !== 4'hF) proto_errs <= proto_errs + 1;
    end
  end

  task automatic run_test(input logic [31:0] pat, input int m, output int bcnt);
    mode    = m;
    pattern = pat;
    start   = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    snap_we_a   = ram_if.we_a;
    snap_addr_a = ram_if.addr_a;
    snap_data_a = ram_if.data_a;
    bcnt = 0;
    while (busy === 1'b1 && bcnt < 2000) begin
      bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [121:0] ports;
    rst = 1'b1; start = 1'b0; pattern = '0;
    repeat (3) @(negedge clk);
    ports = {ram_if.we_a, ram_if.we_b, ram_if.addr_a, ram_if.addr_b, ram_if.be_a,
             ram_if.be_b, ram_if.data_a, ram_if.data_b, ram_if.data_a[15:0]};
    checks++; if ({busy, done, pass} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, pass}); end
    checks++; if ({fail_count, fail_addr, fail_phase} !== 15'd0) begin
      errors++; $display("FAIL reset_fail got %h exp 0", {fail_count, fail_addr, fail_phase}); end
    checks++; if (ports !== '0) begin
      errors++; $display("FAIL reset_ports got %h exp 0", ports); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pass !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got pass=%b busy=%b exp 0 0", pass, busy); end
  endtask

  task automatic test_ideal;
    int bcnt;
    run_test(32'hA5C3_0F96, 0, bcnt);
    checks++; if ({snap_we_a, snap_addr_a, snap_data_a} !== {1'b1, 6'd0, 32'hA5C3_0F96}) begin
      errors++; $display("FAIL ideal_first_write got we=%b addr=%0d data=%h exp 1 0 a5c30f96",
                         snap_we_a, snap_addr_a, snap_data_a); end
    checks++; if (bcnt !== 258) begin
      errors++; $display("FAIL ideal_busy_len got %0d exp 258", bcnt); end
    checks++; if (done !== 1'b1) begin
      errors++; $display("FAIL ideal_done got %b exp 1", done); end
    checks++; if (pass !== 1'b1 || fail_count !== 8'd0) begin
      errors++; $display("FAIL ideal_result got pass=%b cnt=%0d exp 1 0", pass, fail_count); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ideal_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_stuck_bit;
    int bcnt;
    run_test(32'hFFFF_FFFF, 1, bcnt);
    checks++; if (bcnt !== 258 || done !== 1'b1) begin
      errors++; $display("FAIL stuck_timing got busy=%0d done=%b exp 258 1", bcnt, done); end
    checks++; if (fail_count !== 8'd2) begin
      errors++; $display("FAIL stuck_count got %0d exp 2", fail_count); end
    checks++; if (fail_addr !== 6'd5 || fail_phase !== 1'b0) begin
      errors++; $display("FAIL stuck_first got addr=%0d phase=%b exp 5 0", fail_addr, fail_phase); end
    checks++; if (pass !== 1'b0) begin
      errors++; $display("FAIL stuck_pass got %b exp 0", pass); end
    @(negedge clk);
  endtask

  task automatic test_ignore_be;
    int bcnt;
    run_test(32'hA5C3_0F96, 2, bcnt);
    checks++; if (fail_count !== 8'd64) begin
      errors++; $display("FAIL ignore_be_count got %0d exp 64", fail_count); end
    checks++; if (fail_addr !== 6'd0 || fail_phase !== 1'b1) begin
      errors++; $display("FAIL ignore_be_first got addr=%0d phase=%b exp 0 1", fail_addr, fail_phase); end
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL ignore_be_pass got pass=%b done=%b exp 0 1", pass, done); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int bcnt, ndone;
    mode = 0; pattern = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, pass, fail_count, fail_addr, fail_phase} !== 18'd0) begin
      errors++; $display("FAIL abort_outputs got %h exp 0",
                         {busy, done, pass, fail_count, fail_addr, fail_phase}); end
    checks++; if ({ram_if.we_a, ram_if.we_b, ram_if.addr_a, ram_if.addr_b, ram_if.be_a,
                   ram_if.be_b, ram_if.data_a, ram_if.data_b} !== '0) begin
      errors++; $display("FAIL abort_ports got addr_a=%0d addr_b=%0d exp 0",
                         ram_if.addr_a, ram_if.addr_b); end
    rst = 1'b0;
    ndone = 0;
    repeat (300) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin
      errors++; $display("FAIL abort_no_done got %0d active cycles exp 0", ndone); end
    run_test(32'h1234_5678, 0, bcnt);
    checks++; if (bcnt !== 258 || pass !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL abort_rerun got busy=%0d pass=%b done=%b exp 258 1 1",
                         bcnt, pass, done); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t[3];
    int n;
    n = 0; mode = 0; pattern = 32'h0F0F_3C3C; start = 1'b1;
    for (int i = 0; i < 1200 && n < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t[n] = cyc;
        n++;
      end
    end
    checks++; if (n !== 3) begin
      errors++; $display("FAIL b2b_done_count got %0d exp 3", n); end
    else begin
      checks++; if (t[1] - t[0] !== 260) begin
        errors++; $display("FAIL b2b_period1 got %0d exp 260", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 260) begin
        errors++; $display("FAIL b2b_period2 got %0d exp 260", t[2] - t[1]); end
    end
    checks++; if (pass !== 1'b1) begin
      errors++; $display("FAIL b2b_pass got %b exp 1", pass); end
    start = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_settle got busy=%b exp 0", busy); end
  endtask

  task automatic test_protocol;
    checks++; if (proto_errs !== 0) begin
      errors++; $display("FAIL protocol got %0d violations exp 0", proto_errs); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck_bit();
    test_ignore_be();
    test_abort();
    test_back_to_back();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
